// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: memory geometry, the read-only
// button address, the seven-segment register addresses and the FSM state encoding.
package dmem_pkg;

   localparam int            AW            = 8;
   localparam int            DW            = 32;
   localparam logic [AW-1:0] IO_ADDR       = 8'd2;
   localparam logic [AW-1:0] SEG_DATA_ADDR = 8'd0;
   localparam logic [AW-1:0] SEG_EN_ADDR   = 8'd1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SERVE = 2'd1;
   localparam logic [1:0] ACK   = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone eligible port wins outright,
// a tie goes to the port that did not win last time.
module rr_pick2 (
   input  logic [1:0] eligible,
   input  logic       last_grant,
   output logic       valid,
   output logic       gnt
);

   assign valid = |eligible;
   assign gnt   = (eligible == 2'b11) ? ~last_grant : eligible[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store unit (port 0) and the debug loader (port 1) over req/ack handshakes.
module dmem_arbiter import dmem_pkg::*; #(
   parameter int            AW      = dmem_pkg::AW,
   parameter int            DW      = dmem_pkg::DW,
   parameter logic [AW-1:0] IO_ADDR = AW'(dmem_pkg::IO_ADDR),
   parameter bit            RR_INIT = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   output logic          err0,

   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          err1,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata
);

   logic [1:0]    state;
   logic          gnt;
   logic          last_grant;
   logic [1:0]    eligible;
   logic          pick_valid;
   logic          pick_gnt;
   logic          serve;
   logic          we_gnt;
   logic [AW-1:0] addr_gnt;
   logic          io_hit;

   // A port being acked this cycle must wait its turn, which is what forces
   // strict alternation under continuous contention.
   always_comb begin
      // NOTE: assign a default before any conditional update so no latch is inferred.
      eligible = {req1, req0};
      if (state == ACK) eligible[gnt] = 1'b0;
   end

   rr_pick2 u_pick (
      .eligible   (eligible),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .gnt        (pick_gnt)
   );

   assign serve    = (state == SERVE);
   assign we_gnt   = gnt ? we1   : we0;
   assign addr_gnt = gnt ? addr1 : addr0;
   assign io_hit   = (addr_gnt == IO_ADDR);

   // Decoded from state so an async reset during SERVE kills the write before the falling edge.
   assign mem_addr  = (serve && gnt) ? addr1  : addr0;
   assign mem_wdata = (serve && gnt) ? wdata1 : wdata0;
   assign mem_wr    = serve && we_gnt && !io_hit;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_grant <= RR_INIT;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE, ACK: begin
               if (pick_valid) begin
                  state      <= SERVE;
                  gnt        <= pick_gnt;
                  last_grant <= pick_gnt;
               end else begin
                  state <= IDLE;
               end
            end
            SERVE: begin
               state <= ACK;
               // Read data is captured for writes as well; the requester may ignore it.
               if (gnt) begin
                  rdata1 <= mem_rdata;
                  ack1   <= 1'b1;
                  err1   <= we_gnt && io_hit;
               end else begin
                  rdata0 <= mem_rdata;
                  ack0   <= 1'b1;
                  err0   <= we_gnt && io_hit;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected acks and memory
// writes, independent monitors pop and compare on every falling edge.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req0, we0, ack0, err0;
   logic [7:0]  addr0;
   logic [31:0] wdata0, rdata0;
   logic        req1, we1, ack1, err1;
   logic [7:0]  addr1;
   logic [31:0] wdata1, rdata1;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_wr;

   typedef struct {
      int          port;
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } ack_exp_t;

   typedef struct {
      int          cyc;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_exp_t;

   ack_exp_t    ack_q[$];
   wr_exp_t     wr_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          t0;
   logic [31:0] mem [0:255];
   bit          loaded     = 1'b0;

   dmem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .we0       (we0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .ack0      (ack0),
      .rdata0    (rdata0),
      .err0      (err0),
      .req1      (req1),
      .we1       (we1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .ack1      (ack1),
      .rdata1    (rdata1),
      .err1      (err1),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory model: falling-edge write, combinational read, button at address 2.
   always @(negedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[3] <= 32'h0000_0033;
         mem[5] <= 32'h0000_0055;
         loaded <= 1'b1;
      end else if (mem_wr) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = (mem_addr == 8'd2) ? 32'h0000_A5A5 : mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ack(input int port, input int c, input logic [31:0] rd, input logic e);
      ack_exp_t x;
      x.port = port; x.cyc = c; x.rdata = rd; x.err = e;
      ack_q.push_back(x);
   endtask

   task automatic push_wr(input int c, input logic [7:0] a, input logic [31:0] d);
      wr_exp_t x;
      x.cyc = c; x.addr = a; x.data = d;
      wr_q.push_back(x);
   endtask

   // Ack monitor
   always @(negedge clk) begin
      ack_exp_t e;
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? ack0 : ack1) begin
               if (ack_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_ack: port %0d acked at cycle %0d, expected none", p, cyc);
               end else begin
                  e = ack_q.pop_front();
                  check("ack_port",  p,   e.port);
                  check("ack_cycle", cyc, e.cyc);
                  check("ack_rdata", (p == 0) ? rdata0 : rdata1, e.rdata);
                  check("ack_err",   {31'b0, (p == 0) ? err0 : err1}, {31'b0, e.err});
               end
            end
         end
      end
   end

   // Memory write monitor
   always @(negedge clk) begin
      wr_exp_t w;
      if (mem_wr) begin
         if (wr_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: addr %h data %h at cycle %0d, expected none", mem_addr, mem_wdata, cyc);
         end else begin
            w = wr_q.pop_front();
            check("wr_cycle", cyc,       w.cyc);
            check("wr_addr",  mem_addr,  w.addr);
            check("wr_data",  mem_wdata, w.data);
         end
      end
   end

   // One requester transaction: raise req, hold until ack, release (or keep) after the ack cycle.
   task automatic do_txn(input int p, input logic we, input logic [7:0] a,
                         input logic [31:0] d, input bit last);
      bit seen = 1'b0;
      if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (p == 0) ? ack0 : ack1;
      end
      if (!seen) begin
         compared++;
         mismatched++;
         $display("FAIL ack_timeout: port %0d got no ack, expected one within 40 cycles", p);
      end
      @(posedge clk); #1;
      if (last) begin
         if (p == 0) req0 = 1'b0; else req1 = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack0",   ack0,   0);
      check("rst_ack1",   ack1,   0);
      check("rst_err0",   err0,   0);
      check("rst_err1",   err1,   0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_mem_wr", mem_wr, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: reset asserted in the SERVE cycle cancels the write
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 32'h99;
      @(posedge clk); #1;
      check("t1_serve_mem_wr", mem_wr, 1);
      rst_n = 1'b0;
      #1;
      check("t1_mem_wr_dropped", mem_wr, 0);
      check("t1_ack0", ack0, 0);
      check("t1_ack1", ack1, 0);
      check("t1_err0", err0, 0);
      check("t1_err1", err1, 0);
      check("t1_state", dut.state, IDLE);
      req0 = 1'b0; we0 = 1'b0;
      @(negedge clk); #1;
      check("t1_mem5_unchanged", mem[5], 32'h55);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2: single write then read-back on port 0
      t0 = cyc;
      push_wr(t0 + 1, 8'h10, 32'hDEAD_BEEF);
      push_ack(0, t0 + 2, 32'hDEAD_BEEF, 1'b0);
      do_txn(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b1);
      t0 = cyc;
      push_ack(0, t0 + 2, 32'hDEAD_BEEF, 1'b0);
      do_txn(0, 1'b0, 8'h10, 32'h0, 1'b1);

      // 3: simultaneous requests straight from reset, port 0 wins the tie
      do_reset();
      t0 = cyc;
      push_ack(0, t0 + 2, 32'h33, 1'b0);
      push_wr(t0 + 3, 8'h04, 32'h7);
      push_ack(1, t0 + 4, 32'h7, 1'b0);
      fork
         do_txn(0, 1'b0, 8'h03, 32'h0, 1'b1);
         do_txn(1, 1'b1, 8'h04, 32'h7, 1'b1);
      join

      // 4: continuous contention, port 0 writes 0x40+i, port 1 reads it back
      t0 = cyc;
      for (int k = 0; k < 10; k++) begin
         push_ack(k % 2, t0 + 2 + 2 * k, 32'h1000 + k / 2, 1'b0);
         if (k % 2 == 0) push_wr(t0 + 1 + 2 * k, 8'h40 + 8'(k / 2), 32'h1000 + k / 2);
      end
      fork
         for (int i = 0; i < 5; i++) do_txn(0, 1'b1, 8'h40 + 8'(i), 32'h1000 + i, i == 4);
         for (int j = 0; j < 5; j++) do_txn(1, 1'b0, 8'h40 + 8'(j), 32'h0, j == 4);
      join

      // 5: write to the button address is rejected and flagged
      t0 = cyc;
      push_ack(1, t0 + 2, 32'h0000_A5A5, 1'b1);
      do_txn(1, 1'b1, 8'd2, 32'h1234, 1'b1);

      // 6: lone request after idle gap is granted at once
      repeat (5) @(posedge clk);
      #1;
      t0 = cyc;
      push_ack(1, t0 + 2, 32'hDEAD_BEEF, 1'b0);
      do_txn(1, 1'b0, 8'h10, 32'h0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("ack_q_drained", ack_q.size(), 0);
      check("wr_q_drained",  wr_q.size(),  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter sharing the single-port, 256-word data memory between the CPU load/store unit (port 0) and the debug/program loader (port 1). Each requester uses a req/ack handshake. The arbiter drives the memory address, write data and write strobe, and captures the asynchronous read data into a per-port register. It sits between the requesters and the data memory, which writes on the falling clock edge and reads combinationally.

Parameters:
AW, 8, memory word-address width
DW, 32, data width
IO_ADDR, 2, read-only button address; writes to it are rejected and flagged
RR_INIT, 1, reset value of last_grant, so port 0 wins the first tie

Ports:
clk  in  1  system clock, posedge-sequenced
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  AW  port 0 word address
wdata0  in  DW  port 0 write data
ack0  out  1  one-cycle completion pulse
rdata0  out  DW  port 0 read data, valid while ack0=1
err0  out  1  pulses with ack0 if a write targeted IO_ADDR
req1/we1/addr1/wdata1/ack1/rdata1/err1  same as port 0, for port 1
mem_addr  out  AW  to data memory address
mem_wdata  out  DW  to data memory write data
mem_wr  out  1  to data memory write enable
mem_rdata  in  DW  from data memory read data (combinational)

Behaviour:
- FSM states: IDLE, SERVE, ACK. Registers: state, gnt (1 bit), last_grant, rdata0/1, ack0/1, err0/1.
- Reset (async, rst_n=0): state=IDLE; gnt=0; last_grant=RR_INIT; ack*, err*=0; rdata*=0. mem_wr is decoded from state, so it drops to 0 immediately. A reset asserted during SERVE before the falling edge cancels that write.
- Arbitration, done in IDLE and ACK:
  - Only one eligible request: grant it.
  - Both eligible: grant !last_grant.
  - In ACK, the port currently being acked is ineligible for that cycle.
- IDLE: on an eligible request, move to SERVE, load gnt, and set last_grant=gnt. With no request, stay in IDLE.
- SERVE (exactly 1 cycle):
  - mem_addr and mem_wdata come from the granted port.
  - mem_wr = we_gnt && (addr_gnt != IO_ADDR).
  - At the next posedge: rdata_gnt <= mem_rdata (captured for writes too); ack_gnt <= 1; err_gnt <= we_gnt && addr==IO_ADDR; state moves to ACK.
- ACK (1 cycle): ack_gnt=1. Arbitrate as above. Go to SERVE with the new grant if one exists, else IDLE. ack and err return to 0 after this cycle.
- Outside SERVE: mem_wr=0; mem_addr and mem_wdata hold the port-0 values (don't-care for memory).
- Latency: req sampled in IDLE at cycle N; SERVE in N+1; ack in N+2. Back-to-back requests on alternating ports give one transaction per 2 cycles.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1. A requester re-asserting req in its own ACK cycle is not re-granted before the other port.
- Requester protocol violation (dropping req before ack): the transaction still completes and the ack is still issued. The requester must ignore it.
- rdata* holds its last captured value until the next ack to that port.
- Address wrap: AW bits only, no range checking beyond IO_ADDR.

Decomposition:
- Shared package dmem_pkg: AW, DW, IO_ADDR, SEG_DATA_ADDR=0, SEG_EN_ADDR=1, and the FSM state encoding (IDLE=2'd0, SERVE=2'd1, ACK=2'd2).
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker taking eligible[1:0] and last_grant and returning valid and gnt.
- The arbiter itself stays a single flat module.

Test Plan:
1. Reset mid-SERVE: port 0 write to addr 5; assert rst_n=0 in the SERVE cycle before the falling edge -> mem_wr=0 immediately, mem[5] unchanged, all acks/errs 0, state IDLE.
2. Single port-0 write: addr=8'h10, wdata=32'hDEADBEEF -> mem_wr=1 only in cycle N+1, ack0 pulse in N+2, err0=0. A following read of 8'h10 returns rdata0=32'hDEADBEEF with ack0 two cycles after req.
3. Simultaneous requests from reset: both ports request (port 0 read addr 3, port 1 write addr 4 value 7) -> port 0 served first (RR_INIT=1), then port 1 in the cycle right after ack0. Total: ack0 at N+2, ack1 at N+4.
4. Continuous contention: both reqs held high for 10 transactions, each port re-requesting in its own ACK cycle -> grant sequence 0,1,0,1...; no port granted twice in a row.
5. IO protection: port 1 write to addr 2 -> mem_wr stays 0; ack1 and err1 pulse together; rdata1 equals button value (mem_rdata=16'hA5A5 zero-extended).
6. Idle gaps: a single req1 after 5 idle cycles -> granted immediately regardless of last_grant; ack1 exactly 2 cycles after req1 rises.
